// File: rtl/fp_pkg.sv
// Shared single-precision floating-point definitions for the sequential FP
// units: the IEEE 754 field layout, the rounding-mode encodings, the special
// constants, the add/sub controller state set and a leading-zero counter.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_e;

  localparam logic [31:0] QNAN       = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Leading zeros of a 27-bit significand (hidden bit + 23 + G/R/S).
  // An all-zero input returns 27.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic found;
    lzc27 = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        lzc27 = 5'(26 - i);
        found = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational rounding and packing of a normalised single-precision value.
// Ports:
//   sign      - result sign
//   exp_in    - biased exponent after normalisation (signed, may be <= 0)
//   sig_in    - 27-bit significand: [26] hidden bit, [25:3] fraction,
//               [2] guard, [1] round, [0] sticky
//   rm        - rounding mode (101-111 behave as RNE)
//   result    - packed IEEE 754 result
//   overflow  - biased exponent reached 255 after rounding
//   underflow - normalised exponent was <= 0; result flushed to signed zero
module fp_round_pack
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [26:0]       sig_in,
  input  logic [2:0]        rm,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow
);

  logic              lsb;
  logic              grd;
  logic              rs;
  logic              inc;
  logic              ovf_to_inf;
  logic [24:0]       sig_r;
  logic signed [9:0] exp_r;

  always_comb begin
    lsb = sig_in[3];
    grd = sig_in[2];
    rs  = sig_in[1] | sig_in[0];

    case (rmode_e'(rm))
      RM_RTZ: begin
        inc        = 1'b0;
        ovf_to_inf = 1'b0;
      end
      RM_RDN: begin
        inc        = sign & (grd | rs);
        ovf_to_inf = sign;
      end
      RM_RUP: begin
        inc        = ~sign & (grd | rs);
        ovf_to_inf = ~sign;
      end
      RM_RMM: begin
        inc        = grd;
        ovf_to_inf = 1'b1;
      end
      default: begin
        inc        = grd & (rs | lsb);
        ovf_to_inf = 1'b1;
      end
    endcase

    // A round carry out of the 24-bit significand leaves 1.000..0, so a
    // plain right shift and exponent bump renormalise it.
    sig_r = {1'b0, sig_in[26:3]} + {24'd0, inc};
    exp_r = exp_in;
    if (sig_r[24]) begin
      sig_r = {1'b0, sig_r[24:1]};
      exp_r = exp_in + 10'sd1;
    end

    result    = {sign, exp_r[7:0], sig_r[22:0]};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (exp_in <= 10'sd0) begin
      underflow = 1'b1;
      result    = {sign, 31'd0};
    end else if (exp_r >= 10'sd255) begin
      overflow = 1'b1;
      result   = ovf_to_inf ? {sign, POS_INF[30:0]} : {sign, MAX_FINITE[30:0]};
    end
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE 754 single-precision add/subtract unit, one operation in
// flight, valid/ready handshakes on both sides.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid / in_ready - operand handshake (in_ready high only in IDLE)
//   fp_a, fp_b, op      - operands; op=1 computes A-B
//   r_mode              - rounding mode (RNE, RTZ, RDN, RUP, RMM)
//   out_valid/out_ready - result handshake
//   fp_result           - rounded result, held until accepted
//   overflow, underflow - result flags, zero whenever out_valid is low
// Latency from the accepting edge to out_valid is 3 + NORM_CYCLES edges.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int NORM_CYCLES = 1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_a,
  input  logic [31:0] fp_b,
  input  logic        op,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_result,
  output logic        overflow,
  output logic        underflow
);

  // Control state (reset)
  state_e      state_q, state_d;
  logic [7:0]  norm_cnt_q, norm_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] fp_result_q, fp_result_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  // Datapath state (no reset)
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [2:0]        rm_q, rm_d;
  logic              special_q, special_d;
  logic [31:0]       special_val_q, special_val_d;
  logic              zero_sign_q, zero_sign_d;
  logic              sign_q, sign_d;
  logic [7:0]        exp_q, exp_d;
  logic [26:0]       sig_l_q, sig_l_d;
  logic [26:0]       sig_s_q, sig_s_d;
  logic              eff_sub_q, eff_sub_d;
  logic [27:0]       sum_q, sum_d;
  logic signed [9:0] nexp_q, nexp_d;
  logic [26:0]       nsig_q, nsig_d;
  logic              nzero_q, nzero_d;

  // Alignment helpers
  fp32_t       fa, fb, lg, sm;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [7:0]  diff;
  logic [23:0] sig_lg, sig_sm;
  logic [26:0] ext_sm, lost_mask, algn;
  logic        spec_hit, zsign;
  logic [31:0] spec_val;

  // Normalisation helpers
  logic [4:0]        lz;
  logic [26:0]       norm_sig;
  logic signed [9:0] norm_exp;

  // Rounder outputs
  logic [31:0] rp_result;
  logic        rp_overflow, rp_underflow;

  fp_round_pack u_round_pack (
    .sign      (sign_q),
    .exp_in    (nexp_q),
    .sig_in    (nsig_q),
    .rm        (rm_q),
    .result    (rp_result),
    .overflow  (rp_overflow),
    .underflow (rp_underflow)
  );

  // ---- ALIGN: unpack, classify, order by magnitude, align the smaller ----
  always_comb begin
    fa     = fp32_t'(a_q);
    fb     = fp32_t'(b_q);
    a_nan  = (&fa.exp) & (|fa.man);
    b_nan  = (&fb.exp) & (|fb.man);
    a_inf  = (&fa.exp) & ~(|fa.man);
    b_inf  = (&fb.exp) & ~(|fb.man);
    // Denormals are flushed: an exponent of zero is a signed zero.
    a_zero = ~(|fa.exp);
    b_zero = ~(|fb.exp);
    swap   = (b_zero ? 31'd0 : b_q[30:0]) > (a_zero ? 31'd0 : a_q[30:0]);
    lg     = swap ? fb : fa;
    sm     = swap ? fa : fb;
    sig_lg = (lg.exp == 8'd0) ? 24'd0 : {1'b1, lg.man};
    sig_sm = (sm.exp == 8'd0) ? 24'd0 : {1'b1, sm.man};
    diff   = lg.exp - sm.exp;
    ext_sm = {sig_sm, 3'b000};
    lost_mask = (27'd1 << diff) - 27'd1;
    if (diff >= 8'd27) begin
      algn = {26'd0, |sig_sm};
    end else begin
      algn = (ext_sm >> diff) | {26'd0, |(ext_sm & lost_mask)};
    end

    spec_hit = a_nan | b_nan | a_inf | b_inf;
    if (a_nan | b_nan | (a_inf & b_inf & (fa.sign ^ fb.sign))) begin
      spec_val = QNAN;
    end else if (a_inf) begin
      spec_val = {fa.sign, POS_INF[30:0]};
    end else begin
      spec_val = {fb.sign, POS_INF[30:0]};
    end

    // Sign of an exact-zero sum: two like-signed zeros keep their sign,
    // any other cancellation is +0 except under round-down.
    if (a_zero & b_zero & (fa.sign == fb.sign)) begin
      zsign = fa.sign;
    end else begin
      zsign = (rmode_e'(rm_q) == RM_RDN);
    end
  end

  // ---- NORM: carry shift-right or leading-zero shift-left ----
  always_comb begin
    lz = lzc27(sum_q[26:0]);
    if (sum_q[27]) begin
      norm_sig = {sum_q[27:2], sum_q[1] | sum_q[0]};
      norm_exp = $signed({2'b00, exp_q}) + 10'sd1;
    end else begin
      norm_sig = sum_q[26:0] << lz;
      norm_exp = $signed({2'b00, exp_q}) - $signed({5'd0, lz});
    end
  end

  // ---- Next-state and datapath update ----
  always_comb begin
    state_d       = state_q;
    norm_cnt_d    = norm_cnt_q;
    out_valid_d   = out_valid_q;
    fp_result_d   = fp_result_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    a_d           = a_q;
    b_d           = b_q;
    rm_d          = rm_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    zero_sign_d   = zero_sign_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    sig_l_d       = sig_l_q;
    sig_s_d       = sig_s_q;
    eff_sub_d     = eff_sub_q;
    sum_d         = sum_q;
    nexp_d        = nexp_q;
    nsig_d        = nsig_q;
    nzero_d       = nzero_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = fp_a;
          b_d     = fp_b ^ {op, 31'd0};
          rm_d    = r_mode;
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        special_d     = spec_hit;
        special_val_d = spec_val;
        zero_sign_d   = zsign;
        sign_d        = lg.sign;
        exp_d         = lg.exp;
        sig_l_d       = {sig_lg, 3'b000};
        sig_s_d       = algn;
        eff_sub_d     = fa.sign ^ fb.sign;
        state_d       = ST_ADD;
      end
      ST_ADD: begin
        // |large| >= |small|, so the difference never goes negative.
        sum_d      = eff_sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                               : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
        norm_cnt_d = 8'd0;
        state_d    = ST_NORM;
      end
      ST_NORM: begin
        nsig_d  = norm_sig;
        nexp_d  = norm_exp;
        nzero_d = (sum_q == 28'd0);
        if (norm_cnt_q >= 8'(NORM_CYCLES - 1)) begin
          state_d = ST_ROUND;
        end else begin
          norm_cnt_d = norm_cnt_q + 8'd1;
        end
      end
      ST_ROUND: begin
        if (special_q) begin
          fp_result_d = special_val_q;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end else if (nzero_q) begin
          fp_result_d = {zero_sign_q, 31'd0};
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end else begin
          fp_result_d = rp_result;
          overflow_d  = rp_overflow;
          underflow_d = rp_underflow;
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      norm_cnt_q  <= 8'd0;
      out_valid_q <= 1'b0;
      fp_result_q <= 32'd0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      norm_cnt_q  <= norm_cnt_d;
      out_valid_q <= out_valid_d;
      fp_result_q <= fp_result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q           <= a_d;
    b_q           <= b_d;
    rm_q          <= rm_d;
    special_q     <= special_d;
    special_val_q <= special_val_d;
    zero_sign_q   <= zero_sign_d;
    sign_q        <= sign_d;
    exp_q         <= exp_d;
    sig_l_q       <= sig_l_d;
    sig_s_q       <= sig_s_d;
    eff_sub_q     <= eff_sub_d;
    sum_q         <= sum_d;
    nexp_q        <= nexp_d;
    nsig_q        <= nsig_d;
    nzero_q       <= nzero_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign fp_result = fp_result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
Multi-cycle IEEE 754 single-precision add/subtract unit with valid/ready handshakes on both sides. It computes A+B or A-B under the `op` select. Subtraction is done as addition with B's sign flipped. It is the registered, flow-controlled counterpart of the combinational add/sub path and is driven by the sequential fp_alu issue logic. Only one operation is in flight at a time.

Parameters:
- NORM_CYCLES, 1, extra normalisation stages. 1 gives fixed latency 4; each additional stage adds one cycle of latency.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and op valid
- in_ready  out  1  unit can accept; high only in IDLE
- fp_a  in  32  operand A (IEEE 754 single)
- fp_b  in  32  operand B (IEEE 754 single)
- op  in  1  0 = A+B, 1 = A-B
- r_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 behave as RNE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- fp_result  out  32  rounded result
- overflow  out  1  result overflowed (valid with out_valid)
- underflow  out  1  result underflowed or was flushed (valid with out_valid)

Behaviour:
- Reset: clock is clk; reset is synchronous and active-high on rst. On reset: state=IDLE, in_ready=1, out_valid=0, fp_result=0, overflow=0, underflow=0. Reset mid-operation aborts the operation; no result is ever presented for it.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch fp_a, fp_b^(op<<31), and r_mode, then go to ALIGN. Inputs are ignored in every other state.
  - ALIGN: unpack both operands; denormal inputs are treated as signed zero. Swap so |A|>=|B|. Right-shift B's 24-bit significand by the exponent difference with guard, round and sticky bits; a difference >=27 collapses B into sticky.
  - ADD: add significands if the signs are equal, else subtract. Width is 28 bits (carry + 24 + G/R/S).
  - NORM: on a carry, shift right 1 and increment the exponent (sticky ORs in the dropped bit). Otherwise left-shift by the leading-zero count in one cycle and decrement the exponent.
  - ROUND: apply r_mode to G/R/S; a round carry renormalises. Pack the result, set the flags, and go to DONE with out_valid=1.
  - DONE: hold fp_result and the flags stable while out_ready=0. On out_valid&out_ready, go to IDLE with out_valid=0. Back-to-back issue is therefore not possible; throughput is one op per 5+ cycles.
- Latency: out_valid rises on the 4th rising edge after the accepting edge (NORM_CYCLES=1).
- Special cases (resolved in ALIGN; they bypass arithmetic but take the same latency):
  - Any NaN input gives 0x7FC00000, flags 0.
  - +inf + -inf (after the op flip) gives 0x7FC00000, flags 0.
  - inf op finite gives the correctly signed inf, flags 0.
- Exact zero result: +0, except RDN gives -0. Both operands zero with the same sign keep that sign.
- Overflow: biased exponent >=255 after rounding sets overflow=1. The result is inf for RNE and RMM, and for RUP when positive or RDN when negative. Otherwise the result is 0x7F7FFFFF with the sign applied.
- Underflow: normalised exponent <=0 sets underflow=1 and flushes the result to signed zero.
- Flags are 0 whenever out_valid=0.

Decomposition:
- Shared package fp_pkg:
  - typedef fp32_t (packed struct: sign, exp[7:0], man[22:0]).
  - r_mode enum constants RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM.
  - Constants QNAN=32'h7FC00000, POS_INF, MAX_FINITE.
  - State enum for this FSM.
- One sub-module, fp_round_pack: combinational rounding, overflow/underflow detection and packing. It is reusable by the multiplier.
- Leading-zero count is a package function.

Test Plan:
- Add: 0x3F800000 + 0x3F800000, op=0, RNE -> fp_result=0x40000000, flags 0, out_valid on the 4th edge after accept.
- Subtract and exact cancellation:
  - 0x40400000 - 0x3F800000, op=1 -> 0x40000000.
  - 0x3F800000 - 0x3F800000 with RNE -> 0x00000000; with RDN -> 0x80000000.
- Specials:
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000, flags 0.
  - 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF with RNE -> 0x7F800000, overflow=1; with RTZ -> 0x7F7FFFFF, overflow=1.
- Underflow: 0x00800000 - 0x00800001 -> signed zero 0x80000000, underflow=1.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles: result and flags stable, in_ready=0, new in_valid ignored.
  - Release out_ready: IDLE and in_ready=1 next cycle.
  - Assert rst during the ADD state: out_valid never rises, and all outputs match their reset values the following cycle.
